cla_result_fifo: RTL and testbench

Downstream stage of the 32-bit carry-lookahead adder. Captures each adder result (sum, carry-out) together with the operand sign bits, derives N/Z/C/V status flags, and buffers results in a small FIFO with a valid/ready handshake toward the consumer. It decouples the combinational adder from a consumer that may stall, and it preserves result order.

---
 rtl/cla_result_fifo.sv | 115 +++++++++++
 tb/tb_cla_result_fifo.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/cla_result_fifo.sv
// cla_result_fifo: captures CLA adder results, derives N/Z/C/V flags and
// buffers them in an order-preserving circular FIFO with valid/ready handshake.
module cla_result_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     x_msb,
  input  logic                     y_msb,
  input  logic [WIDTH-1:0]         sum,
  input  logic                     cout,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_sum,
  output logic [3:0]               out_flags,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = WIDTH + 4;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_PARTIAL,
    ST_FULL
  } state_t;

  state_t          state_q, state_d;
  logic [EW-1:0]   mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic            push, pop;
  logic [3:0]      in_flags;

  // Status flags of the incoming result: {N, Z, C, V}
  always_comb begin
    in_flags[3] = sum[WIDTH-1];
    in_flags[2] = (sum == '0);
    in_flags[1] = cout;
    in_flags[0] = (x_msb == y_msb) && (sum[WIDTH-1] != x_msb);
  end

  // Handshake qualification and next-state computation
  always_comb begin
    push     = in_valid && (state_q != ST_FULL);
    pop      = out_ready && (state_q != ST_EMPTY);
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + ONE_CNT;
    end else if (pop && !push) begin
      count_d = count_q - ONE_CNT;
    end
    state_d = state_q;
    case (state_q)
      ST_EMPTY: begin
        if (push) state_d = ST_PARTIAL;
      end
      ST_PARTIAL: begin
        if (push && !pop && (count_q == FULL_CNT - ONE_CNT)) begin
          state_d = ST_FULL;
        end else if (pop && !push && (count_q == ONE_CNT)) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (pop) state_d = ST_PARTIAL;
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // Control FSM: occupancy state, pointers and count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_EMPTY;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage, cleared on reset so no stale data is ever visible
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[AW'(i)] <= '0;
      end
    end else if (push) begin
      mem_q[wr_ptr_q] <= {sum, in_flags};
    end
  end

  // Outputs come from registered state only
  always_comb begin
    in_ready  = (state_q != ST_FULL);
    out_valid = (state_q != ST_EMPTY);
    out_sum   = mem_q[rd_ptr_q][EW-1:4];
    out_flags = mem_q[rd_ptr_q][3:0];
    count     = count_q;
  end

endmodule

// File: tb/tb_cla_result_fifo.sv
// Self-checking bench for cla_result_fifo: flag vectors, full/empty corners,
// mid-operation reset and a randomised run against a queue model.
module tb_cla_result_fifo;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic              x_msb;
  logic              y_msb;
  logic [WIDTH-1:0]  sum;
  logic              cout;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  out_sum;
  logic [3:0]        out_flags;
  logic [2:0]        count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] s;
    logic [3:0]  f;
  } exp_t;

  typedef struct {
    logic        xm;
    logic        ym;
    logic [31:0] s;
    logic        co;
    logic [3:0]  f;
  } vec_t;

  exp_t q[$];
  vec_t vecs[6];

  cla_result_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .x_msb(x_msb), .y_msb(y_msb), .sum(sum), .cout(cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_flags(out_flags), .count(count)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] model_flags(input logic xm, input logic ym,
                                             input logic [31:0] s, input logic co);
    logic [3:0] f;
    f[3] = s[31];
    f[2] = (s == 32'd0);
    f[1] = co;
    f[0] = (xm == ym) && (s[31] != xm);
    return f;
  endfunction

  task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, compare against the model, advance model and DUT
  task automatic cycle(input logic iv, input logic xm, input logic ym,
                       input logic [31:0] s, input logic co, input logic ordy);
    exp_t e;
    logic mpush, mpop;
    in_valid  = iv;
    x_msb     = xm;
    y_msb     = ym;
    sum       = s;
    cout      = co;
    out_ready = ordy;
    #1;
    chk("count", {33'd0, count}, 36'(q.size()));
    chk("in_ready", {35'd0, in_ready}, {35'd0, (q.size() != DEPTH)});
    chk("out_valid", {35'd0, out_valid}, {35'd0, (q.size() != 0)});
    if (q.size() != 0) begin
      chk("out_sum", {4'd0, out_sum}, {4'd0, q[0].s});
      chk("out_flags", {32'd0, out_flags}, {32'd0, q[0].f});
    end
    mpop  = ordy && (q.size() != 0);
    mpush = iv && (q.size() != DEPTH);
    if (mpop) void'(q.pop_front());
    if (mpush) begin
      e.s = s;
      e.f = model_flags(xm, ym, s, co);
      q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{xm: 1'b0, ym: 1'b0, s: 32'h0000_0003, co: 1'b0, f: 4'b0000};
    vecs[1] = '{xm: 1'b1, ym: 1'b0, s: 32'h0000_0000, co: 1'b1, f: 4'b0110};
    vecs[2] = '{xm: 1'b0, ym: 1'b0, s: 32'h8000_0000, co: 1'b0, f: 4'b1001};
    vecs[3] = '{xm: 1'b1, ym: 1'b1, s: 32'hFFFF_FFFE, co: 1'b1, f: 4'b1010};
    vecs[4] = '{xm: 1'b1, ym: 1'b1, s: 32'h7FFF_FFFF, co: 1'b1, f: 4'b0011};
    vecs[5] = '{xm: 1'b0, ym: 1'b1, s: 32'h1234_5678, co: 1'b0, f: 4'b0000};

    rst = 1'b1; in_valid = 1'b0; x_msb = 1'b0; y_msb = 1'b0;
    sum = '0; cout = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", {33'd0, count}, 36'd0);
    chk("rst_out_valid", {35'd0, out_valid}, 36'd0);
    chk("rst_in_ready", {35'd0, in_ready}, 36'd1);
    chk("rst_out_sum", {4'd0, out_sum}, 36'd0);
    chk("rst_out_flags", {32'd0, out_flags}, 36'd0);
    rst = 1'b0;

    // Flag vectors: push with out_ready high, visible next cycle, popped on the following edge
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, vecs[i].xm, vecs[i].ym, vecs[i].s, vecs[i].co, 1'b1);
      chk("vec_out_valid", {35'd0, out_valid}, 36'd1);
      chk("vec_out_sum", {4'd0, out_sum}, {4'd0, vecs[i].s});
      chk("vec_out_flags", {32'd0, out_flags}, {32'd0, vecs[i].f});
      cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
      chk("vec_count_after_pop", {33'd0, count}, 36'd0);
    end

    // Fill to full, hold a refused entry, then drain in order
    for (int i = 3; i <= 6; i++) cycle(1'b1, 1'b0, 1'b0, 32'(i), 1'b0, 1'b0);
    chk("full_count", {33'd0, count}, 36'd4);
    chk("full_in_ready", {35'd0, in_ready}, 36'd0);
    cycle(1'b1, 1'b0, 1'b0, 32'd21, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 32'd21, 1'b0, 1'b0);
    chk("held_count", {33'd0, count}, 36'd4);
    chk("held_head", {4'd0, out_sum}, 36'd3);
    cycle(1'b1, 1'b0, 1'b0, 32'd21, 1'b0, 1'b1);
    chk("full_pop_no_push", {33'd0, count}, 36'd3);
    chk("full_pop_head", {4'd0, out_sum}, 36'd4);
    cycle(1'b1, 1'b0, 1'b0, 32'd21, 1'b0, 1'b1);
    chk("push_pop_count", {33'd0, count}, 36'd3);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
    chk("drained_count", {33'd0, count}, 36'd0);

    // Steady push+pop at count 2, streaming across several pointer wraps
    cycle(1'b1, 1'b0, 1'b0, 32'd28, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 32'd29, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 32'd30, 1'b0, 1'b1);
    chk("simul_count", {33'd0, count}, 36'd2);
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, 1'b0, 32'(100 + i), 1'b0, 1'b1);
    chk("wrap_count", {33'd0, count}, 36'd2);
    for (int i = 0; i < 2; i++) cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1);

    // Asynchronous reset between edges
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 32'(50 + i), 1'b0, 1'b0);
    chk("pre_rst_count", {33'd0, count}, 36'd3);
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", {35'd0, out_valid}, 36'd0);
    chk("arst_count", {33'd0, count}, 36'd0);
    chk("arst_in_ready", {35'd0, in_ready}, 36'd1);
    chk("arst_out_sum", {4'd0, out_sum}, 36'd0);
    q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    cycle(1'b1, 1'b0, 1'b0, 32'd30, 1'b0, 1'b0);
    chk("post_rst_sum", {4'd0, out_sum}, 36'd30);
    chk("post_rst_count", {33'd0, count}, 36'd1);
    cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1);

    // Randomised traffic against the queue model
    for (int i = 0; i < 1000; i++) begin
      logic [31:0] rs;
      rs = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            rs, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      chk("count_range", {35'd0, (count <= 3'd4)}, 36'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
